// File: rtl/tlul_host_adapter_if.sv
// TL-UL type package and the host/bus interface bundle for tlul_host_adapter.
// master = local host plus TL-UL device side, slave = the adapter itself.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 64;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = 8;
  localparam int TL_AUW = 16;
  localparam int TL_DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [TL_AUW-1:0] TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

interface tlul_host_adapter_if;
  import top_pkg::*;

  logic             req_i;
  logic             gnt_o;
  logic [TL_AW-1:0] addr_i;
  logic             we_i;
  logic [63:0]      wdata_i;
  logic [7:0]       be_i;
  logic             valid_o;
  logic [63:0]      rdata_o;
  logic             err_o;
  tl_h2d_t          tl_o;
  tl_d2h_t          tl_i;

  modport master (
    output req_i, addr_i, we_i, wdata_i, be_i, tl_i,
    input  gnt_o, valid_o, rdata_o, err_o, tl_o
  );

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, be_i, tl_i,
    output gnt_o, valid_o, rdata_o, err_o, tl_o
  );
endinterface

// File: rtl/tlul_host_adapter.sv
// req/gnt host port to TL-UL A/D adapter with bounded in-order outstanding tracking.
// Optional: define CEP_TLUL_HOST_ZERO_BE_CHK_EN to complete be_i==0 requests locally with error.
module tlul_host_adapter
  import top_pkg::*;
#(
  parameter int unsigned MAX_REQS = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  tlul_host_adapter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_REQS + 1);
  localparam int unsigned SW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_REQS);
  localparam logic [SW-1:0] LAST_ID = SW'(MAX_REQS - 1);

  logic [CW-1:0] out_cnt_reg, out_cnt_next;
  logic [SW-1:0] src_reg, src_next;
  logic [SW-1:0] exp_reg, exp_next;

  logic       grp_aligned;
  logic [1:0] grp_size;
  logic [2:0] grp_mask;
  logic [2:0] lane_lo;

  logic space, zero_be, a_valid, a_hs, d_hs;
  logic underflow, cnt_inc, cnt_dec, src_mismatch, d_err;

  always_comb begin
    lane_lo = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.be_i[i]) lane_lo = 3'(i);
    end
  end

  // Non-aligned masks fall through to a full-beat size with lane offset zero.
  always_comb begin
    grp_aligned = 1'b1;
    grp_size    = 2'd3;
    grp_mask    = 3'b000;
    case (bus.be_i)
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: begin
        grp_size = 2'd0;
        grp_mask = 3'b111;
      end
      8'h03, 8'h0C, 8'h30, 8'hC0: begin
        grp_size = 2'd1;
        grp_mask = 3'b110;
      end
      8'h0F, 8'hF0: begin
        grp_size = 2'd2;
        grp_mask = 3'b100;
      end
      8'hFF: begin
        grp_size = 2'd3;
        grp_mask = 3'b000;
      end
      default: grp_aligned = 1'b0;
    endcase
  end

  assign space     = (out_cnt_reg < MAX_CNT);
  assign a_valid   = bus.req_i & space & ~zero_be;
  assign a_hs      = a_valid & bus.tl_i.a_ready;
  assign d_hs      = bus.tl_i.d_valid;
  assign underflow = (out_cnt_reg == '0);
  assign cnt_inc   = a_hs;
  assign cnt_dec   = d_hs & ~underflow;

  assign src_mismatch = (bus.tl_i.d_source != TL_AIW'(exp_reg));
  assign d_err        = bus.tl_i.d_error | src_mismatch | underflow;

  always_comb begin
    out_cnt_next = out_cnt_reg;
    src_next     = src_reg;
    exp_next     = exp_reg;
    case ({cnt_inc, cnt_dec})
      2'b10:   out_cnt_next = out_cnt_reg + 1'b1;
      2'b01:   out_cnt_next = out_cnt_reg - 1'b1;
      default: out_cnt_next = out_cnt_reg;
    endcase
    if (a_hs) src_next = (src_reg == LAST_ID) ? '0 : src_reg + 1'b1;
    if (cnt_dec) exp_next = (exp_reg == LAST_ID) ? '0 : exp_reg + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_reg <= '0;
      src_reg     <= '0;
      exp_reg     <= '0;
    end else begin
      out_cnt_reg <= out_cnt_next;
      src_reg     <= src_next;
      exp_reg     <= exp_next;
    end
  end

  always_comb begin
    bus.tl_o           = '0;
    bus.tl_o.a_valid   = a_valid;
    bus.tl_o.a_opcode  = !bus.we_i ? Get : (grp_aligned ? PutFullData : PutPartialData);
    bus.tl_o.a_param   = 3'd0;
    bus.tl_o.a_size    = grp_size;
    bus.tl_o.a_source  = TL_AIW'(src_reg);
    bus.tl_o.a_address = {bus.addr_i[TL_AW-1:3], lane_lo & grp_mask};
    bus.tl_o.a_mask    = bus.be_i;
    bus.tl_o.a_data    = bus.we_i ? bus.wdata_i : '0;
    bus.tl_o.a_user    = TL_A_USER_DEFAULT;
    bus.tl_o.d_ready   = 1'b1;
  end

`ifdef CEP_TLUL_HOST_ZERO_BE_CHK_EN
  logic lc_reg, lc_next, local_gnt;

  // A pending local completion yields to a same-cycle D beat and retries next cycle.
  assign zero_be   = (bus.be_i == 8'h00);
  assign local_gnt = bus.req_i & zero_be & ~lc_reg;
  assign lc_next   = local_gnt | (lc_reg & d_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lc_reg <= 1'b0;
    else         lc_reg <= lc_next;
  end

  assign bus.gnt_o   = a_hs | local_gnt;
  assign bus.valid_o = d_hs | lc_reg;
  assign bus.err_o   = d_hs ? d_err : lc_reg;
  assign bus.rdata_o = d_hs ? bus.tl_i.d_data : '0;
`else
  assign zero_be     = 1'b0;
  assign bus.gnt_o   = a_hs;
  assign bus.valid_o = d_hs;
  assign bus.err_o   = d_hs & d_err;
  assign bus.rdata_o = bus.tl_i.d_data;
`endif

  logic unused_in;
  assign unused_in = ^{bus.addr_i[2:0], bus.tl_i.d_opcode, bus.tl_i.d_param,
                       bus.tl_i.d_size, bus.tl_i.d_sink, bus.tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Self-checking bench for tlul_host_adapter: directed cases with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_tlul_host_adapter;
  import top_pkg::*;

  localparam int MAX_REQS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlul_host_adapter_if bus();

  tlul_host_adapter #(.MAX_REQS(MAX_REQS)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int m_cnt = 0, m_src = 0, m_exp = 0;
  bit m_lc = 0;
  bit m_gnt_last = 0;

  logic [7:0] aligned_tbl [7] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Expected A fields from the lane-group rules: a group is aligned when its
  // enabled lanes are contiguous, a power-of-two count and start on a multiple of it.
  function automatic void ref_a(input logic [7:0] be, input logic [31:0] addr, input logic we,
                                output int op, output int size, output logic [31:0] a_addr);
    int n = 0, lo = -1, hi = -1;
    bit al;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        n++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    al = (n == 1 || n == 2 || n == 4 || n == 8) && (hi - lo + 1 == n) && (lo % n == 0);
    size = !al ? 3 : (n == 1) ? 0 : (n == 2) ? 1 : (n == 4) ? 2 : 3;
    a_addr = {addr[31:3], 3'b000} + (al ? 32'(lo) : 32'd0);
    op = !we ? 4 : (al ? 0 : 1);
  endfunction

  // compare process
  bit e_av, e_lgnt, e_gnt, e_valid, e_err, dv, zero, a_hs, d_ok;
  int e_op, e_size;
  logic [31:0] e_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_src = 0; m_exp = 0; m_lc = 0;
    end
`ifdef CEP_TLUL_HOST_ZERO_BE_CHK_EN
    zero = (bus.be_i == 8'h00);
`else
    zero = 1'b0;
`endif
    e_av    = bus.req_i && (m_cnt < MAX_REQS) && !zero;
    e_lgnt  = bus.req_i && zero && !m_lc;
    e_gnt   = (e_av && bus.tl_i.a_ready) || e_lgnt;
    dv      = bus.tl_i.d_valid;
    e_valid = dv || m_lc;
    e_err   = dv ? (bus.tl_i.d_error || int'(bus.tl_i.d_source) != m_exp || m_cnt == 0) : m_lc;

    chk("gnt", bus.gnt_o, e_gnt);
    chk("a_valid", bus.tl_o.a_valid, e_av);
    chk("d_ready", bus.tl_o.d_ready, 1);
    chk("valid", bus.valid_o, e_valid);
    chk("err", bus.err_o, e_err);
    if (e_valid) chk("rdata", bus.rdata_o, dv ? bus.tl_i.d_data : 64'd0);
    if (e_av) begin
      ref_a(bus.be_i, bus.addr_i, bus.we_i, e_op, e_size, e_addr);
      chk("a_opcode", bus.tl_o.a_opcode, e_op);
      chk("a_size", bus.tl_o.a_size, e_size);
      chk("a_address", bus.tl_o.a_address, e_addr);
      chk("a_mask", bus.tl_o.a_mask, bus.be_i);
      chk("a_source", bus.tl_o.a_source, m_src);
      chk("a_data", bus.tl_o.a_data, bus.we_i ? bus.wdata_i : 64'd0);
      chk("a_param", bus.tl_o.a_param, 0);
      chk("a_user", bus.tl_o.a_user, TL_A_USER_DEFAULT);
    end
    if (e_gnt)
      $display("[%0t] A grant we=%0b addr=%h be=%h src=%0d local=%0b",
               $time, bus.we_i, bus.addr_i, bus.be_i, m_src, e_lgnt);
    if (e_valid)
      $display("[%0t] D resp err=%0b rdata=%h", $time, bus.err_o, bus.rdata_o);

    if (rst_n) begin
      a_hs = e_av && bus.tl_i.a_ready;
      d_ok = dv && (m_cnt > 0);
      m_cnt = m_cnt + (a_hs ? 1 : 0) - (d_ok ? 1 : 0);
      if (a_hs) m_src = (m_src + 1) % MAX_REQS;
      if (d_ok) m_exp = (m_exp + 1) % MAX_REQS;
      m_lc = e_lgnt || (m_lc && dv);
    end
    m_gnt_last = e_gnt;
  end

  task automatic set_in(input bit req, input bit we, input logic [31:0] addr, input logic [7:0] be,
                        input logic [63:0] wd, input bit ar, input bit dv_i, input int ds,
                        input bit de, input logic [63:0] dd);
    bus.req_i = req;
    bus.we_i = we;
    bus.addr_i = addr;
    bus.be_i = be;
    bus.wdata_i = wd;
    bus.tl_i.a_ready = ar;
    bus.tl_i.d_valid = dv_i;
    bus.tl_i.d_source = 8'(ds);
    bus.tl_i.d_error = de;
    bus.tl_i.d_data = dd;
  endtask

  task automatic drive(input bit req, input bit we, input logic [31:0] addr, input logic [7:0] be,
                       input logic [63:0] wd, input bit ar, input bit dv_i, input int ds,
                       input bit de, input logic [63:0] dd);
    @(posedge clk);
    #1;
    set_in(req, we, addr, be, wd, ar, dv_i, ds, de, dd);
    #2;
  endtask

  initial begin
    bus.tl_i = '0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_a_valid", bus.tl_o.a_valid, 0);
    chk("rst_d_ready", bus.tl_o.d_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1, 1, 32'h1006, 8'hC0, 64'h1111_2222_3333_4444, 1, 0, 0, 0, 0);
    chk("w1_op", bus.tl_o.a_opcode, 0);
    chk("w1_size", bus.tl_o.a_size, 1);
    chk("w1_addr", bus.tl_o.a_address, 32'h1006);
    chk("w1_mask", bus.tl_o.a_mask, 8'hC0);
    chk("w1_src", bus.tl_o.a_source, 0);
    chk("w1_gnt", bus.gnt_o, 1);

    drive(1, 1, 32'h2000, 8'h5A, 64'h55, 1, 0, 0, 0, 0);
    chk("w2_op", bus.tl_o.a_opcode, 1);
    chk("w2_size", bus.tl_o.a_size, 3);
    chk("w2_addr", bus.tl_o.a_address, 32'h2000);
    chk("w2_mask", bus.tl_o.a_mask, 8'h5A);
    chk("w2_src", bus.tl_o.a_source, 1);

    drive(1, 0, 32'h3000, 8'hF0, 0, 1, 1, 0, 0, 64'hDEAD_BEEF_0000_0001);
    chk("full_gnt", bus.gnt_o, 0);
    chk("full_a_valid", bus.tl_o.a_valid, 0);
    chk("r_valid", bus.valid_o, 1);
    chk("r_rdata", bus.rdata_o, 64'hDEAD_BEEF_0000_0001);
    chk("r_err", bus.err_o, 0);

    drive(1, 0, 32'h3000, 8'hF0, 0, 1, 0, 0, 0, 0);
    chk("rd_gnt", bus.gnt_o, 1);
    chk("rd_op", bus.tl_o.a_opcode, 4);
    chk("rd_size", bus.tl_o.a_size, 2);
    chk("rd_addr", bus.tl_o.a_address, 32'h3004);
    chk("rd_src", bus.tl_o.a_source, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mis_valid", bus.valid_o, 1);
    chk("mis_err", bus.err_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    chk("derr_err", bus.err_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("uflow_valid", bus.valid_o, 1);
    chk("uflow_err", bus.err_o, 1);

    drive(1, 0, 32'h40, 8'hFF, 0, 1, 0, 0, 0, 0);
    chk("after_uf_gnt", bus.gnt_o, 1);
    chk("after_uf_src", bus.tl_o.a_source, 1);
    drive(1, 0, 32'h45, 8'h01, 0, 1, 0, 0, 0, 0);
    chk("b0_size", bus.tl_o.a_size, 0);
    chk("b0_addr", bus.tl_o.a_address, 32'h40);
    chk("b0_src", bus.tl_o.a_source, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rstmid_uf_err", bus.err_o, 1);
    drive(1, 1, 32'h80, 8'h0F, 64'hAB, 1, 0, 0, 0, 0);
    chk("rstmid_src", bus.tl_o.a_source, 0);
    chk("rstmid_gnt", bus.gnt_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 64'h77);
    chk("rstmid_resp_err", bus.err_o, 0);

`ifdef CEP_TLUL_HOST_ZERO_BE_CHK_EN
    drive(1, 1, 32'h100, 8'h00, 64'h9, 1, 0, 0, 0, 0);
    chk("zbe_gnt", bus.gnt_o, 1);
    chk("zbe_a_valid", bus.tl_o.a_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zbe_valid", bus.valid_o, 1);
    chk("zbe_err", bus.err_o, 1);
    chk("zbe_rdata", bus.rdata_o, 0);
`else
    drive(1, 0, 32'h100, 8'h00, 0, 1, 0, 0, 0, 0);
    chk("zbe_gnt", bus.gnt_o, 1);
    chk("zbe_op", bus.tl_o.a_opcode, 4);
    chk("zbe_size", bus.tl_o.a_size, 3);
    chk("zbe_mask", bus.tl_o.a_mask, 0);
    chk("zbe_src", bus.tl_o.a_source, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 64'h5);
    chk("zbe_resp_err", bus.err_o, 0);
`endif

    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (c == 300) rst_n = 1'b0;
      if (c == 302) rst_n = 1'b1;
      if (!(bus.req_i && !m_gnt_last)) begin
        bus.req_i = ($urandom_range(0, 9) < 6);
        bus.we_i = 1'($urandom);
        bus.addr_i = $urandom;
        bus.wdata_i = {$urandom, $urandom};
        case ($urandom_range(0, 4))
          0: bus.be_i = 8'(1 << $urandom_range(0, 7));
          1: bus.be_i = aligned_tbl[$urandom_range(0, 6)];
          2, 3: bus.be_i = 8'($urandom);
          default: bus.be_i = 8'h00;
        endcase
      end
      bus.tl_i.a_ready = ($urandom_range(0, 9) < 7);
      bus.tl_i.d_valid = ($urandom_range(0, 99) < 35);
      bus.tl_i.d_source = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, MAX_REQS - 1)) : 8'(m_exp);
      bus.tl_i.d_error = ($urandom_range(0, 9) == 0);
      bus.tl_i.d_data = {$urandom, $urandom};
    end

    @(posedge clk);
    #1 set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_host_adapter.md
# tlul_host_adapter

Initiator-side TL-UL master that converts a simple req/gnt memory port into well-formed 64-bit TL-UL A-channel requests and returns D-channel responses in order. Every request it issues passes the device-side A-channel legality rules: opcode, size/address alignment and mask-lane checks. It sits between CEP-local requesters (LLKI control logic, DMA-style sequencers) and the TL-UL crossbar. It tracks a bounded number of outstanding transactions with in-order source IDs.

## Interface
- `MAX_REQS`, default 2: maximum outstanding transactions, 1..16. Source IDs are 0..MAX_REQS-1.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset. Asynchronous, active-low.
- `req_i` in, 1: request valid from the local host.
- `gnt_o` out, 1: request accepted this cycle.
- `addr_i` in, `top_pkg::TL_AW`: byte address.
- `we_i` in, 1: 1 = write, 0 = read.
- `wdata_i` in, 64: write data, lane-aligned to `addr_i[31:3]`.
- `be_i` in, 8: byte enables, one per lane.
- `valid_o` out, 1: response valid.
- `rdata_o` out, 64: read data, `tl_i.d_data`.
- `err_o` out, 1: response error, qualified by `valid_o`.
- `tl_o` out, `tl_h2d_t`: TL-UL A channel plus `d_ready`.
- `tl_i` in, `tl_d2h_t`: TL-UL D channel plus `a_ready`.

## Operation
- **Opcode.** Read: `Get`. Write: `PutFullData` when `be_i` forms a naturally aligned contiguous group, else `PutPartialData`.
- **Aligned groups:**
  - size 0: any single bit.
  - size 1: `8'h03`, `8'h0C`, `8'h30`, `8'hC0`.
  - size 2: `8'h0F`, `8'hF0`.
  - size 3: `8'hFF`.
- **Aligned group encoding:**
  - `a_size` = group size.
  - `a_address` = `{addr_i[AW-1:3], lane offset of lowest set bit}`, masked to the size alignment.
  - `a_mask` = `be_i`.
- **Non-aligned `be_i`, reads or writes:** `a_size`=3, `a_address[2:0]`=0, `a_mask`=`be_i`.
- **Fixed A-channel fields:** `a_param`=0. `a_data` = `wdata_i` for writes, 0 for reads. `a_user` = package default.
- **Outstanding counter `out_cnt`** (width clog2(MAX_REQS+1)):
  - +1 on A handshake (`a_valid & a_ready`).
  - −1 on D handshake (`d_valid & d_ready`).
  - Both in the same cycle: unchanged.
- **Flow control.** `space` = `out_cnt < MAX_REQS`.
  - `a_valid` = `req_i & space`.
  - `gnt_o` = `a_valid & a_ready`.
- **Source IDs.**
  - Issue pointer `src_q`: `a_source` = `src_q`; increments modulo MAX_REQS on each A handshake.
  - Expect pointer `exp_q`: increments modulo MAX_REQS on each D handshake.
- **Responses.** `d_ready` is tied 1.
  - `valid_o` = `d_valid`.
  - `err_o` = `d_error | (d_source != exp_q)`. A source mismatch flags the error and still advances `exp_q`.
- **Underflow.** A D beat arriving with `out_cnt`==0 produces `valid_o`=1, `err_o`=1 and no counter change.

## Timing
- **Request latency.** Combinational: A channel valid the same cycle as `req_i`. `gnt_o` same cycle as `a_ready`.
- **Response latency.** Combinational pass-through; zero cycles from D beat to `valid_o`.
- **Holding rules.**
  - The host must hold `req_i` and all request inputs stable until `gnt_o`.
  - Once `a_valid` rises it is not withdrawn by the adapter unless `req_i` drops.
  - A same-cycle D response frees a slot on the next cycle, not the current one; there is no combinational `d_valid`→`a_valid` path.
- **Reset values.** `out_cnt`, `src_q`, `exp_q` = 0. `gnt_o`, `valid_o`, `err_o`, `a_valid` = 0 while `req_i`=0. `d_ready`=1.
- **Reset mid-transaction.** Reset while outstanding clears all state. Late D beats are then handled by the underflow rule.

## Configuration
- **`CEP_TLUL_HOST_ZERO_BE_CHK_EN` defined.**
  - A request with `be_i`==0 is not issued on TL-UL: `a_valid`=0, `gnt_o`=1 in the same cycle.
  - It completes locally one cycle later: `valid_o`=1, `err_o`=1, `rdata_o`=0.
  - A local completion colliding with a D beat is held one cycle; the D beat is delivered first.
  - At most one local completion is pending; further `be_i`==0 requests are not granted until it drains.
- **Macro undefined.** `be_i`==0 is issued as `Get`/`PutPartialData` size 3, mask 0, which is legal on the bus.

## Test plan
- Write `addr`=0x1006, `be`=8'hC0 → `PutFullData`, `a_size`=1, `a_address`=0x1006, `a_mask`=8'hC0, `a_source`=0.
- Write `addr`=0x2000, `be`=8'h5A → `PutPartialData`, `a_size`=3, `a_address`=0x2000, `a_mask`=8'h5A.
- Read `be`=8'hF0 at 0x3000 → `Get`, `a_size`=2, `a_address`=0x3004. Response `d_data`=64'hDEAD_BEEF_0000_0001 → `rdata_o` matches, `err_o`=0.
- MAX_REQS=2, `a_ready`=1, no D beats:
  - Three back-to-back requests → first two granted with sources 0, 1; third stalls with `gnt_o`=0.
  - One D beat → third request granted on the following cycle with source 0.
- D beat with `d_source`=1 while `exp_q`=0 → `valid_o`=1, `err_o`=1, `exp_q` advances to 1. `d_error`=1 on an otherwise correct beat → `err_o`=1.
- With the macro defined, `be_i`=0 → `gnt_o`=1, no `a_valid`, next cycle `valid_o`=1, `err_o`=1. Asserting `rst_ni`=0 with 2 outstanding → counters return to 0.
